// File: rtl/atom_ctrl_pkg.sv
// atom_ctrl_pkg: shared CONTROL-side definitions for the instruction loader.
//   - descriptor class enum and loader FSM state enum
//   - opcode / func7 constants and ALUop codes 0..9
//   - encode_desc(): descriptor -> 32-bit RV word (inverse of CONTROL decode)
package atom_ctrl_pkg;

  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_ARITH = 2'd1,
    CLS_WORD  = 2'd2,
    CLS_JALR  = 2'd3
  } desc_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_ARITH = 7'h13;
  localparam logic [6:0] OP_WORD  = 7'h1B;
  localparam logic [6:0] OP_JALR  = 7'h67;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SLL  = 6'd1;
  localparam logic [5:0] ALU_SLT  = 6'd2;
  localparam logic [5:0] ALU_SLTU = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SRL  = 6'd5;
  localparam logic [5:0] ALU_SRA  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_AND  = 6'd8;
  localparam logic [5:0] ALU_JALR = 6'd9;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_word_t;

  // SRL and SRA share func3 5; func7 tells them apart.
  function automatic logic [2:0] arith_func3(input logic [5:0] aluop);
    logic [2:0] f3;
    case (aluop)
      ALU_ADD:  f3 = 3'd0;
      ALU_SLL:  f3 = 3'd1;
      ALU_SLT:  f3 = 3'd2;
      ALU_SLTU: f3 = 3'd3;
      ALU_XOR:  f3 = 3'd4;
      ALU_SRL:  f3 = 3'd5;
      ALU_SRA:  f3 = 3'd5;
      ALU_OR:   f3 = 3'd6;
      ALU_AND:  f3 = 3'd7;
      default:  f3 = 3'd0;
    endcase
    return f3;
  endfunction

  function automatic enc_word_t encode_desc(
    input desc_class_t cls,
    input logic [5:0]  aluop,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [11:0] imm
  );
    enc_word_t   r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        shift;
    logic [11:0] upper;
    r.legal = 1'b0;
    opc     = OP_LOAD;
    f3      = aluop[2:0];
    shift   = aluop inside {ALU_SLL, ALU_SRL, ALU_SRA};
    case (cls)
      CLS_LOAD: begin
        opc     = OP_LOAD;
        shift   = 1'b0;
        r.legal = aluop inside {ALU_ADD, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL};
      end
      CLS_ARITH: begin
        opc     = OP_ARITH;
        f3      = arith_func3(aluop);
        r.legal = (aluop <= ALU_AND);
      end
      CLS_WORD: begin
        opc     = OP_WORD;
        f3      = arith_func3(aluop);
        r.legal = aluop inside {ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA};
      end
      default: begin
        opc     = OP_JALR;
        f3      = 3'd0;
        shift   = 1'b0;
        r.legal = (aluop == ALU_JALR);
      end
    endcase
    upper  = shift ? {((aluop == ALU_SRA) ? F7_ALT : F7_BASE), imm[4:0]} : imm;
    r.word = {upper, rs1, f3, rd, opc};
    return r;
  endfunction

endpackage

// File: rtl/instr_loader_fifo.sv
// instr_loader_fifo: synchronous FIFO for encoded instruction words.
//   clk_i/rst_i     clock, synchronous active-high reset (flushes)
//   push_i/data_i   write side; a push while full is dropped unless popping
//   pop_i/data_o    read side; data_o is the head entry
//   count_o         occupancy, full_o / empty_o status
module instr_loader_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == ($clog2(DEPTH)+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end
endmodule

// File: rtl/instr_loader_enc.sv
// instr_loader_enc: writer side of the instruction path.
// Accepts decoded descriptors over valid/ready, re-encodes them to RV words
// through a one-cycle staging register, buffers them in a FIFO and writes
// them to instruction memory at sequential addresses from BASE_ADDR.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   load_start_i, load_end_i         session begin / no more descriptors
//   desc_valid_i, desc_ready_o       descriptor handshake
//   desc_class_i/aluop/rd/rs1/imm    descriptor fields
//   mem_ready_i                      memory accepts the write this cycle
//   iwr_en_o, iaddr_o, idata_o       memory write port
//   regrst_o, busy_o                 high for the whole session
//   done_o, err_o                    one-cycle status pulses
// Optional: define INSTR_LOADER_CHECKSUM_EN to add csum_o, the XOR of all
// words written in the current session.
module instr_loader_enc
  import atom_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_start_i,
  input  logic        load_end_i,
  input  logic        desc_valid_i,
  output logic        desc_ready_o,
  input  logic [1:0]  desc_class_i,
  input  logic [5:0]  desc_aluop_i,
  input  logic [4:0]  desc_rd_i,
  input  logic [4:0]  desc_rs1_i,
  input  logic [11:0] desc_imm_i,
  input  logic        mem_ready_i,
  output logic        iwr_en_o,
  output logic [31:0] iaddr_o,
  output logic [31:0] idata_o,
  output logic        regrst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] csum_o
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  load_state_t   state;
  logic          stg_valid;
  enc_word_t     stg;
  logic [IW-1:0] widx;
  logic          ovf;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;

  logic accept;
  logic push;
  logic pop;
  logic wr_fire;
  logic discard;

  // load_end_i wins over a same-cycle handshake, so ready is withdrawn then.
  assign desc_ready_o = (state == ST_LOAD) && !load_end_i && !fifo_full &&
                        ((fifo_count + CW'(stg_valid)) < CW'(FIFO_DEPTH));
  assign accept  = desc_valid_i && desc_ready_o;
  assign push    = stg_valid && stg.legal;

  // Once the last memory word is written, remaining words are dropped.
  assign iwr_en_o = !fifo_empty && !ovf;
  assign discard  = !fifo_empty && ovf;
  assign wr_fire  = iwr_en_o && mem_ready_i;
  assign pop      = wr_fire || discard;

  assign iaddr_o  = iwr_en_o ? (BASE_ADDR + 32'({widx, 2'b00})) : '0;
  assign idata_o  = iwr_en_o ? fifo_head : '0;
  assign busy_o   = (state != ST_IDLE);
  assign regrst_o = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign err_o    = (stg_valid && !stg.legal) || discard;

  instr_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (stg.word),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      stg_valid <= 1'b0;
      stg       <= '0;
      widx      <= '0;
      ovf       <= 1'b0;
    end else begin
      stg_valid <= accept;
      stg       <= encode_desc(desc_class_t'(desc_class_i), desc_aluop_i,
                               desc_rd_i, desc_rs1_i, desc_imm_i);
      if (wr_fire) begin
        if (widx == IW'(IMEM_WORDS - 1)) ovf  <= 1'b1;
        else                             widx <= widx + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (load_start_i) begin
            state <= ST_LOAD;
            widx  <= '0;
            ovf   <= 1'b0;
          end
        end
        ST_LOAD:  if (load_end_i) state <= ST_DRAIN;
        ST_DRAIN: if (!stg_valid && fifo_empty) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                                  csum_o <= '0;
    else if (state == ST_IDLE && load_start_i)  csum_o <= '0;
    else if (wr_fire)                           csum_o <= csum_o ^ fifo_head;
  end
`endif

endmodule

// File: tb/tb_instr_loader_enc.sv
// tb_instr_loader_enc: directed self-checking bench for instr_loader_enc.
// dut uses default parameters; dut2 (IMEM_WORDS=2) shares all inputs and is
// only inspected in the address-overflow scenario.
module tb_instr_loader_enc;
  logic        clk = 1'b0;
  logic        rst_i, load_start_i, load_end_i, desc_valid_i, mem_ready_i;
  logic [1:0]  desc_class_i;
  logic [5:0]  desc_aluop_i;
  logic [4:0]  desc_rd_i, desc_rs1_i;
  logic [11:0] desc_imm_i;
  logic        desc_ready_o, iwr_en_o, regrst_o, busy_o, done_o, err_o;
  logic [31:0] iaddr_o, idata_o;
  logic        ov_desc_ready, ov_iwr_en, ov_regrst, ov_busy, ov_done, ov_err;
  logic [31:0] ov_iaddr, ov_idata;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] csum_o, ov_csum;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] wr_q[$];
  logic [63:0] wr2_q[$];
  int err_cnt, err2_cnt, done_cnt;

  always #5 clk = ~clk;

  instr_loader_enc #(.FIFO_DEPTH(4), .IMEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .load_end_i(load_end_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_class_i(desc_class_i),
    .desc_aluop_i(desc_aluop_i), .desc_rd_i(desc_rd_i), .desc_rs1_i(desc_rs1_i),
    .desc_imm_i(desc_imm_i), .mem_ready_i(mem_ready_i), .iwr_en_o(iwr_en_o),
    .iaddr_o(iaddr_o), .idata_o(idata_o), .regrst_o(regrst_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .csum_o(csum_o)
`endif
  );

  instr_loader_enc #(.FIFO_DEPTH(4), .IMEM_WORDS(2), .BASE_ADDR(32'h0)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .load_end_i(load_end_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(ov_desc_ready), .desc_class_i(desc_class_i),
    .desc_aluop_i(desc_aluop_i), .desc_rd_i(desc_rd_i), .desc_rs1_i(desc_rs1_i),
    .desc_imm_i(desc_imm_i), .mem_ready_i(mem_ready_i), .iwr_en_o(ov_iwr_en),
    .iaddr_o(ov_iaddr), .idata_o(ov_idata), .regrst_o(ov_regrst), .busy_o(ov_busy),
    .done_o(ov_done), .err_o(ov_err)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .csum_o(ov_csum)
`endif
  );

  // Observe completed writes and status pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (iwr_en_o && mem_ready_i)  wr_q.push_back({iaddr_o, idata_o});
      if (ov_iwr_en && mem_ready_i) wr2_q.push_back({ov_iaddr, ov_idata});
      if (err_o)  err_cnt++;
      if (ov_err) err2_cnt++;
      if (done_o) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [1:0] c, input logic [5:0] a, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [11:0] imm);
    desc_class_i = c;
    desc_aluop_i = a;
    desc_rd_i    = rd;
    desc_rs1_i   = rs1;
    desc_imm_i   = imm;
  endtask

  task automatic clear_obs();
    wr_q.delete();
    wr2_q.delete();
    err_cnt  = 0;
    err2_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_session();
    load_start_i = 1'b1;
    cyc();
    load_start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_o !== 1'b1 && n < 60) begin
      cyc();
      n++;
    end
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_done: done_o=%b expected 1 within 60 cycles", name, done_o);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; load_start_i = 0; load_end_i = 0; desc_valid_i = 0; mem_ready_i = 0;
    set_desc(2'd0, 6'd0, 5'd0, 5'd0, 12'd0);
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({iwr_en_o, desc_ready_o, regrst_o, busy_o, done_o, err_o} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {iwr_en_o, desc_ready_o, regrst_o, busy_o, done_o, err_o});
    end
    tests_run++;
    if (iaddr_o !== 32'h0 || idata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_port: addr=%h data=%h expected 0/0", iaddr_o, idata_o);
    end
  endtask

  task automatic test_single_write();
    clear_obs();
    mem_ready_i = 1'b1;
    start_session();
    set_desc(2'd1, 6'd0, 5'd1, 5'd0, 12'd5);
    desc_valid_i = 1'b1;
    #1;
    tests_run++;
    if ({desc_ready_o, regrst_o, busy_o} !== 3'b111) begin
      tests_failed++;
      $display("FAIL single_load_state: ready/regrst/busy=%b expected 111",
               {desc_ready_o, regrst_o, busy_o});
    end
    cyc();
    desc_valid_i = 1'b0;
    tests_run++;
    if (iwr_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_lat_n1: iwr_en=%b expected 0", iwr_en_o);
    end
    load_end_i = 1'b1;
    cyc();
    load_end_i = 1'b0;
    tests_run++;
    if ({iwr_en_o, iaddr_o, idata_o} !== {1'b1, 32'h0, 32'h00500093}) begin
      tests_failed++;
      $display("FAIL single_write: en=%b addr=%h data=%h expected 1/00000000/00500093",
               iwr_en_o, iaddr_o, idata_o);
    end
    cyc();
    tests_run++;
    if ({iwr_en_o, done_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL single_drain: en/done=%b expected 00", {iwr_en_o, done_o});
    end
    cyc();
    tests_run++;
    if ({done_o, regrst_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL single_done: done/regrst=%b expected 11", {done_o, regrst_o});
    end
    cyc();
    tests_run++;
    if ({done_o, regrst_o, busy_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_idle: done/regrst/busy=%b expected 000", {done_o, regrst_o, busy_o});
    end
    tests_run++;
    if (wr_q.size() != 1 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL single_counts: writes=%0d dones=%0d expected 1/1", wr_q.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[4];
    exp_w[0] = 32'h4030D113;
    exp_w[1] = 32'h000280E7;
    exp_w[2] = 32'h01012283;
    exp_w[3] = 32'h41F3D31B;
    clear_obs();
    mem_ready_i = 1'b1;
    start_session();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       set_desc(2'd1, 6'd6, 5'd2, 5'd1, 12'd3);
        1:       set_desc(2'd3, 6'd9, 5'd1, 5'd5, 12'd0);
        2:       set_desc(2'd0, 6'd2, 5'd5, 5'd2, 12'h010);
        default: set_desc(2'd2, 6'd6, 5'd6, 5'd7, 12'h01F);
      endcase
      desc_valid_i = 1'b1;
      #1;
      tests_run++;
      if (desc_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_ready%0d: ready=%b expected 1", i, desc_ready_o);
      end
      cyc();
    end
    // A descriptor offered together with load_end_i must not be taken.
    set_desc(2'd1, 6'd0, 5'd31, 5'd0, 12'h7FF);
    load_end_i = 1'b1;
    #1;
    tests_run++;
    if (desc_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end_prio: ready=%b expected 0", desc_ready_o);
    end
    cyc();
    desc_valid_i = 1'b0;
    load_end_i   = 1'b0;
    wait_done("b2b");
    tests_run++;
    if (wr_q.size() != 4 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL b2b_count: writes=%0d errs=%0d expected 4/0", wr_q.size(), err_cnt);
    end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== {32'(i * 4), exp_w[i]}) begin
        tests_failed++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, wr_q[i], {32'(i * 4), exp_w[i]});
      end
    end
  endtask

  task automatic test_illegal();
    clear_obs();
    mem_ready_i = 1'b1;
    start_session();
    set_desc(2'd2, 6'd2, 5'd3, 5'd1, 12'd0);
    desc_valid_i = 1'b1;
    cyc();
    desc_valid_i = 1'b0;
    tests_run++;
    if ({err_o, iwr_en_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL illegal_err: err/en=%b expected 10", {err_o, iwr_en_o});
    end
    cyc();
    tests_run++;
    if ({err_o, iwr_en_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL illegal_pulse: err/en=%b expected 00", {err_o, iwr_en_o});
    end
    set_desc(2'd0, 6'd3, 5'd4, 5'd4, 12'd1);
    desc_valid_i = 1'b1;
    cyc();
    desc_valid_i = 1'b0;
    cyc();
    set_desc(2'd1, 6'd0, 5'd3, 5'd2, 12'd1);
    desc_valid_i = 1'b1;
    cyc();
    desc_valid_i = 1'b0;
    load_end_i   = 1'b1;
    cyc();
    load_end_i   = 1'b0;
    wait_done("illegal");
    tests_run++;
    if (wr_q.size() != 1 || err_cnt != 2) begin
      tests_failed++;
      $display("FAIL illegal_count: writes=%0d errs=%0d expected 1/2", wr_q.size(), err_cnt);
    end
    if (wr_q.size() > 0) begin
      tests_run++;
      if (wr_q[0] !== {32'h0, 32'h00110193}) begin
        tests_failed++;
        $display("FAIL illegal_addr: got %h expected 0000000000110193", wr_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] dw[5];
    int   acc;
    logic hs;
    logic stable_ok;
    dw[0] = 32'h00000093; dw[1] = 32'h00100113; dw[2] = 32'h00200193;
    dw[3] = 32'h00300213; dw[4] = 32'h00400293;
    acc = 0;
    stable_ok = 1'b1;
    clear_obs();
    mem_ready_i = 1'b0;
    start_session();
    for (int c = 0; c < 8; c++) begin
      set_desc(2'd1, 6'd0, 5'(acc + 1), 5'd0, 12'(acc));
      desc_valid_i = 1'b1;
      #1;
      hs = desc_ready_o;
      if (iwr_en_o && (iaddr_o !== 32'h0 || idata_o !== dw[0])) stable_ok = 1'b0;
      cyc();
      if (hs) acc++;
    end
    #1;
    tests_run++;
    if (acc != 4 || desc_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full: accepted=%0d ready=%b expected 4/0", acc, desc_ready_o);
    end
    tests_run++;
    if ({iwr_en_o, iaddr_o, idata_o, stable_ok} !== {1'b1, 32'h0, dw[0], 1'b1}) begin
      tests_failed++;
      $display("FAIL bp_stable: en=%b addr=%h data=%h stable=%b expected 1/0/%h/1",
               iwr_en_o, iaddr_o, idata_o, stable_ok, dw[0]);
    end
    mem_ready_i = 1'b1;
    for (int c = 0; c < 20 && acc < 5; c++) begin
      set_desc(2'd1, 6'd0, 5'(acc + 1), 5'd0, 12'(acc));
      desc_valid_i = 1'b1;
      #1;
      hs = desc_ready_o;
      cyc();
      if (hs) acc++;
    end
    desc_valid_i = 1'b0;
    tests_run++;
    if (acc != 5) begin
      tests_failed++;
      $display("FAIL bp_release: accepted=%0d expected 5", acc);
    end
    load_end_i = 1'b1;
    cyc();
    load_end_i = 1'b0;
    wait_done("bp");
    tests_run++;
    if (wr_q.size() != 5) begin
      tests_failed++;
      $display("FAIL bp_count: writes=%0d expected 5", wr_q.size());
    end
    for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
      tests_run++;
      if (wr_q[i] !== {32'(i * 4), dw[i]}) begin
        tests_failed++;
        $display("FAIL bp_word%0d: got %h expected %h", i, wr_q[i], {32'(i * 4), dw[i]});
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] dw[3];
    dw[0] = 32'h00000093; dw[1] = 32'h00100113; dw[2] = 32'h00200193;
    clear_obs();
    mem_ready_i = 1'b1;
    start_session();
    for (int i = 0; i < 3; i++) begin
      set_desc(2'd1, 6'd0, 5'(i + 1), 5'd0, 12'(i));
      desc_valid_i = 1'b1;
      cyc();
    end
    desc_valid_i = 1'b0;
    load_end_i   = 1'b1;
    cyc();
    load_end_i   = 1'b0;
    wait_done("ovf");
    tests_run++;
    if (wr2_q.size() != 2 || err2_cnt != 1) begin
      tests_failed++;
      $display("FAIL ovf_count: writes=%0d errs=%0d expected 2/1", wr2_q.size(), err2_cnt);
    end
    for (int i = 0; i < 2 && i < wr2_q.size(); i++) begin
      tests_run++;
      if (wr2_q[i] !== {32'(i * 4), dw[i]}) begin
        tests_failed++;
        $display("FAIL ovf_word%0d: got %h expected %h", i, wr2_q[i], {32'(i * 4), dw[i]});
      end
    end
    tests_run++;
    if (wr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL ovf_big_count: writes=%0d expected 3", wr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    mem_ready_i = 1'b0;
    start_session();
    for (int i = 0; i < 2; i++) begin
      set_desc(2'd1, 6'd0, 5'(i + 1), 5'd0, 12'(i));
      desc_valid_i = 1'b1;
      cyc();
    end
    desc_valid_i = 1'b0;
    load_end_i   = 1'b1;
    cyc();
    load_end_i   = 1'b0;
    cyc();
    tests_run++;
    if ({busy_o, iwr_en_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL rstmid_pre: busy/en=%b expected 11", {busy_o, iwr_en_o});
    end
    rst_i = 1'b1;
    cyc();
    tests_run++;
    if ({iwr_en_o, regrst_o, busy_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_idle: en/regrst/busy=%b expected 000", {iwr_en_o, regrst_o, busy_o});
    end
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    repeat (5) cyc();
    tests_run++;
    if (wr_q.size() != 0 || iwr_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_flush: writes=%0d en=%b expected 0/0", wr_q.size(), iwr_en_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/instr_loader_enc.md
Name: instr_loader_enc

Overview:
- Writer side of the instruction path. Accepts decoded-form instruction descriptors (class, ALUop, rd, rs1, imm) over a valid/ready handshake.
- Re-encodes each descriptor into a 32-bit RV instruction word. The mapping is the exact inverse of the CONTROL decode table.
- Buffers encoded words in a small FIFO and streams them into instruction memory with IWR enable at sequential addresses.
- Holds the core in register reset for the whole load session.

Parameters:
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)
- IMEM_WORDS, 1024, instruction memory size in 32-bit words
- BASE_ADDR, 32'h0, byte address of first written word

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- load_start_i  in  1  begin load session
- load_end_i  in  1  no further descriptors
- desc_valid_i  in  1  descriptor valid
- desc_ready_o  out  1  descriptor accepted when valid&ready
- desc_class_i  in  2  0=LOAD(7'h03) 1=ARITH(7'h13) 2=WORD(7'h1B) 3=JALR(7'h67)
- desc_aluop_i  in  6  ALUop code (CONTROL encoding)
- desc_rd_i  in  5  destination register
- desc_rs1_i  in  5  source register
- desc_imm_i  in  12  immediate / shamt in [4:0]
- mem_ready_i  in  1  instruction memory accepts write this cycle
- iwr_en_o  out  1  instruction memory write enable
- iaddr_o  out  32  byte write address
- idata_o  out  32  encoded instruction word
- regrst_o  out  1  core register reset, held during session
- busy_o  out  1  session active
- done_o  out  1  one-cycle pulse at session end
- err_o  out  1  one-cycle pulse: illegal descriptor or address overflow

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO empty; address = BASE_ADDR; staging register invalid.
- FSM:
  - IDLE→LOAD on load_start_i; address reloads to BASE_ADDR.
  - LOAD→DRAIN on load_end_i. load_end_i has priority over a same-cycle accept, so the descriptor in that cycle is not accepted.
  - DRAIN→DONE when staging register is invalid and FIFO is empty.
  - DONE→IDLE unconditionally after 1 cycle; done_o=1 in DONE.
  - load_start_i outside IDLE is ignored.
- regrst_o and busy_o are 1 in LOAD, DRAIN and DONE; 0 in IDLE.
- desc_ready_o = (state==LOAD) && (fifo_count + staging_valid < FIFO_DEPTH).
- Encode stage: descriptor accepted in cycle N → registered encoded word in staging at N+1 → pushed into FIFO the same cycle. The earliest iwr_en_o is N+2.
- Encoding:
  - Word layout: opcode by class; instr[11:7]=rd, [19:15]=rs1.
  - LOAD: ALUop ∈{0,1,2,4,5}; func3=ALUop[2:0]; [31:20]=imm.
  - ARITH: ALUop 0..8 → func3 {0,1,2,3,4,5,5,6,7}. Shifts are ALUop 1,5,6: [31:25]=func7 (0, 0, 7'h20), [24:20]=imm[4:0]. Others: [31:20]=imm.
  - WORD: ALUop ∈{0,1,5,6}, same func3/func7 rule as ARITH.
  - JALR: ALUop=9 only; func3=0; [31:20]=imm.
- Illegal class/ALUop combination: descriptor consumed, nothing written, err_o pulses at N+1.
- Write port: when FIFO non-empty, iwr_en_o=1, idata_o=head, iaddr_o=current address. When mem_ready_i=1, pop and advance address by 4. Outputs stay stable while mem_ready_i=0.
- Address overflow: a write at word index IMEM_WORDS-1 pops normally. Any subsequent word is popped and discarded, and err_o pulses once per discarded word. The address saturates and does not wrap.
- Simultaneous staging push and FIFO pop in the same cycle are both allowed.
- Reset mid-session: returns to IDLE, FIFO flushed, regrst_o drops next cycle.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN
- With the macro: extra output csum_o[31:0], the XOR of every word actually written (iwr_en_o&&mem_ready_i). It clears on load_start_i and holds its value after DONE.
- Without the macro: no port and no logic.

Decomposition:
- Shared package atom_ctrl_pkg:
  - class enum
  - opcode constants 7'h03/13/1B/67
  - func7 constants 7'h00/7'h20
  - ALUop localparams 0..9 (ADD, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, JALR)
- One sub-module: instr_loader_fifo (sync FIFO with push/pop/count/full/empty).

Test Plan:
- Start; ARITH aluop0 rd1 rs1 0 imm5; end, mem_ready=1 → one write 0x00500093 at addr 0x0; done_o pulse; regrst_o falls afterwards.
- ARITH aluop6 rd2 rs1 1 imm3 → 0x4030D113. JALR aluop9 rd1 rs1 5 imm0 → 0x000280E7 at addr 0x4.
- WORD aluop2 → err_o pulse at N+1, no write, address unchanged.
- Hold mem_ready_i=0 while pushing 5 descriptors with FIFO_DEPTH=4 → desc_ready_o drops after 4; iwr_en_o/iaddr_o/idata_o stable; release → 5 writes in order, addresses 0x0..0x10.
- IMEM_WORDS=2, 3 valid descriptors → writes at 0x0 and 0x4; third word discarded with err_o pulse.
- rst_i asserted in DRAIN with 2 words queued → next cycle IDLE, iwr_en_o=0, regrst_o=0, no further writes.
